// File: rtl/data_memory_pipelined_pkg.sv
// Shared types for the pipelined data memory: FSM state, response record and
// address-decode helpers.
package data_memory_pipelined_pkg;

    localparam int MemDataW = 32;
    localparam int AddrW    = 32;

    typedef enum logic {
        MEM_INIT,
        MEM_RUN
    } MemState;

    // Response data is sized by MemDataW, so the top DataWidth must match it.
    typedef struct packed {
        logic                valid;
        logic                err;
        logic [MemDataW-1:0] data;
    } MemResp;

    function automatic logic [AddrW-1:0] low_mask(input int bits);
        return (AddrW'(1) << bits) - AddrW'(1);
    endfunction

endpackage

// File: rtl/data_memory_pipelined_delay_line.sv
// Enable-gated shift register of response records with a synchronous
// active-low clear; collapses to a wire when Depth is 0.
module mem_delay_line #(
    parameter type T     = logic,
    parameter int  Depth = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  T     d,
    output T     q
);

    generate
        if (Depth == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clock, reset, enable};
            assign q = d;
        end else begin : g_shift
            T stage_p [Depth];

            always_ff @(posedge clock) begin
                if (!reset) begin
                    for (int i = 0; i < Depth; i++) begin
                        stage_p[i] <= '0;
                    end
                end else if (enable) begin
                    stage_p[0] <= d;
                    for (int i = 1; i < Depth; i++) begin
                        stage_p[i] <= stage_p[i-1];
                    end
                end
            end

            assign q = stage_p[Depth-1];
        end
    endgenerate

endmodule

// File: rtl/data_memory_pipelined.sv
// CPU data-port memory: valid/ready requests, alignment and range checks,
// zeroing sweep after reset and a fixed-latency in-order response pipe.
module data_memory_pipelined
    import data_memory_pipelined_pkg::*;
#(
    parameter int DataWidth    = MemDataW,
    parameter int DataCapacity = 1024,
    parameter int Latency      = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 write,
    input  logic [AddrW-1:0]     addr,
    input  logic [DataWidth-1:0] wData,
    input  logic [DataWidth-1:0] wDataMask,
    output logic                 respValid,
    output logic [DataWidth-1:0] rData,
    output logic                 respErr
);

    localparam int OffW = $clog2(DataWidth / 8);
    localparam int IdxW = $clog2(DataCapacity);

    function automatic logic is_misaligned(input logic [AddrW-1:0] a);
        return (a & low_mask(OffW)) != '0;
    endfunction

    function automatic logic is_out_of_range(input logic [AddrW-1:0] a);
        return (a >> OffW) >= AddrW'(DataCapacity);
    endfunction

    logic [DataWidth-1:0] mem [DataCapacity];

    MemState         state, state_nxt;
    logic [IdxW-1:0] sweep_idx;
    logic            sweep_we;

    logic [IdxW-1:0] req_idx;
    logic            req_err;
    logic            accept;
    logic            store_ok;
    logic            load_ok;

    assign req_idx  = IdxW'(addr >> OffW);
    assign req_err  = is_misaligned(addr) | is_out_of_range(addr);
    assign accept   = reqValid & reqReady;
    assign store_ok = accept & write & ~req_err;
    assign load_ok  = accept & ~write & ~req_err;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= MEM_INIT;
            sweep_idx <= '0;
        end else if (enable) begin
            state <= state_nxt;
            if (state == MEM_INIT) begin
                sweep_idx <= sweep_idx + IdxW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        reqReady  = 1'b0;
        sweep_we  = 1'b0;
        case (state)
            MEM_INIT: begin
                sweep_we = enable;
                if (sweep_idx == IdxW'(DataCapacity - 1)) begin
                    state_nxt = MEM_RUN;
                end
            end
            MEM_RUN: begin
                reqReady = enable;
            end
            default: begin
                state_nxt = MEM_INIT;
            end
        endcase
    end

    // Stores land at the accept edge, so a load one cycle later sees them.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (sweep_we) begin
                mem[sweep_idx] <= '0;
            end else if (store_ok) begin
                mem[req_idx] <= (mem[req_idx] & ~wDataMask) | (wData & wDataMask);
            end
        end
    end

    // Stage p0: array sampled at the accept edge into the first response register.
    logic                vld_p0;
    logic                err_p0;
    logic [MemDataW-1:0] data_p0;
    MemResp              resp_p0;
    MemResp              resp_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
        end else if (enable) begin
            vld_p0 <= accept;
        end
    end

    always_ff @(posedge clock) begin
        if (enable) begin
            err_p0  <= req_err;
            data_p0 <= load_ok ? MemDataW'(mem[req_idx]) : '0;
        end
    end

    assign resp_p0 = '{valid: vld_p0, err: err_p0, data: data_p0};

    // Stages p1..: remaining Latency-1 cycles of response delay.
    mem_delay_line #(
        .T     (MemResp),
        .Depth (Latency - 1)
    ) u_delay (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .d      (resp_p0),
        .q      (resp_q)
    );

    assign respValid = resp_q.valid;
    assign respErr   = resp_q.valid & resp_q.err;
    assign rData     = resp_q.valid ? DataWidth'(resp_q.data) : '0;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Scoreboard bench for data_memory_pipelined with a 16-word array and latency 2.
module tb_data_memory_pipelined;

    localparam int DW  = 32;
    localparam int CAP = 16;
    localparam int LAT = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b1;
    logic          reqValid = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   addr = '0;
    logic [DW-1:0] wData = '0;
    logic [DW-1:0] wDataMask = '0;
    logic          reqReady;
    logic          respValid;
    logic [DW-1:0] rData;
    logic          respErr;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [CAP];
    int            checks = 0;
    int            fails = 0;

    data_memory_pipelined #(
        .DataWidth    (DW),
        .DataCapacity (CAP),
        .Latency      (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .write     (write),
        .addr      (addr),
        .wData     (wData),
        .wDataMask (wDataMask),
        .respValid (respValid),
        .rData     (rData),
        .respErr   (respErr)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(CAP));
    endfunction

    // One clock cycle: retire the visible response, record the accepted request.
    task automatic tick();
        exp_t       e;
        logic [3:0] idx;
        @(negedge clock);
        if (respValid && enable && reset) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_resp: rData=%h respErr=%b, required no response", rData, respErr);
            end else begin
                e = sb.pop_front();
                if (rData !== e.data || respErr !== e.err) begin
                    fails++;
                    $display("FAIL resp_data: rData=%h respErr=%b, required rData=%h respErr=%b",
                             rData, respErr, e.data, e.err);
                end
            end
        end else if (!respValid) begin
            checks++;
            if (rData !== '0 || respErr !== 1'b0) begin
                fails++;
                $display("FAIL idle_outputs: rData=%h respErr=%b, required 0 and 0", rData, respErr);
            end
        end
        if (!reset) begin
            sb.delete();
        end else if (enable && reqValid && reqReady) begin
            e.err  = model_err(addr);
            e.data = '0;
            if (!e.err) begin
                idx = addr[5:2];
                if (write) model[idx] = (model[idx] & ~wDataMask) | (wData & wDataMask);
                else       e.data = model[idx];
            end
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] m);
        reqValid  = 1'b1;
        write     = w;
        addr      = a;
        wData     = d;
        wDataMask = m;
        tick();
        reqValid  = 1'b0;
    endtask

    task automatic idle(input int n);
        reqValid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        int n;
        for (int i = 0; i < CAP; i++) model[i] = '0;
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (reqReady !== 1'b0 || respValid !== 1'b0 || rData !== '0 || respErr !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: reqReady=%b respValid=%b rData=%h respErr=%b, required all 0",
                     reqReady, respValid, rData, respErr);
        end
        reset = 1'b1;
        n = 0;
        @(negedge clock);
        while (reqReady !== 1'b1 && n < 64) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (n != CAP) begin
            fails++;
            $display("FAIL sweep_len: reqReady low for %0d cycles, required %0d", n, CAP);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < CAP; i++) issue(1'b0, 32'(i * 4), '0, '0);
        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_reset: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_store_load();
        issue(1'b1, 32'h8, 32'hDEADBEEF, 32'hFFFFFFFF);
        issue(1'b0, 32'h8, '0, '0);
        checks++;
        if (respValid !== 1'b1 || respErr !== 1'b0 || rData !== '0) begin
            fails++;
            $display("FAIL store_resp_timing: respValid=%b respErr=%b rData=%h, required 1 0 00000000",
                     respValid, respErr, rData);
        end
        tick();
        checks++;
        if (respValid !== 1'b1 || respErr !== 1'b0 || rData !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL load_after_store: respValid=%b respErr=%b rData=%h, required 1 0 deadbeef",
                     respValid, respErr, rData);
        end
        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_store_load: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_mask();
        issue(1'b1, 32'h8, 32'h11223344, 32'h0000FF00);
        issue(1'b0, 32'h8, '0, '0);
        tick();
        checks++;
        if (respValid !== 1'b1 || rData !== 32'hDEAD33EF) begin
            fails++;
            $display("FAIL masked_store: respValid=%b rData=%h, required 1 dead33ef", respValid, rData);
        end
        idle(LAT + 2);
    endtask

    task automatic test_errors();
        issue(1'b0, 32'h6, '0, '0);
        issue(1'b1, 32'h40, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++;
        if (respValid !== 1'b1 || respErr !== 1'b1 || rData !== '0) begin
            fails++;
            $display("FAIL misaligned_err: respValid=%b respErr=%b rData=%h, required 1 1 0",
                     respValid, respErr, rData);
        end
        tick();
        checks++;
        if (respValid !== 1'b1 || respErr !== 1'b1 || rData !== '0) begin
            fails++;
            $display("FAIL range_err: respValid=%b respErr=%b rData=%h, required 1 1 0",
                     respValid, respErr, rData);
        end
        issue(1'b0, 32'h41, '0, '0);
        issue(1'b1, 32'h7C, 32'h12345678, 32'hFFFFFFFF);
        issue(1'b0, 32'h0, '0, '0);
        issue(1'b0, 32'hFFFF_FFFC, '0, '0);
        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_errors: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_freeze();
        issue(1'b1, 32'h0, 32'hA0A0A0A0, 32'hFFFFFFFF);
        issue(1'b1, 32'h4, 32'hB1B1B1B1, 32'hFFFFFFFF);
        idle(LAT + 2);
        issue(1'b0, 32'h0, '0, '0);
        issue(1'b0, 32'h4, '0, '0);
        enable   = 1'b0;
        reqValid = 1'b1;
        write    = 1'b0;
        addr     = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (respValid !== 1'b1 || rData !== 32'hA0A0A0A0 || reqReady !== 1'b0) begin
                fails++;
                $display("FAIL freeze_hold[%0d]: respValid=%b rData=%h reqReady=%b, required 1 a0a0a0a0 0",
                         i, respValid, rData, reqReady);
            end
        end
        enable = 1'b1;
        tick();
        reqValid = 1'b0;
        idle(LAT + 3);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_freeze: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_inflight();
        int n;
        issue(1'b0, 32'h0, '0, '0);
        issue(1'b0, 32'h4, '0, '0);
        reset = 1'b0;
        for (int i = 0; i < CAP; i++) model[i] = '0;
        tick();
        checks++;
        if (respValid !== 1'b0) begin
            fails++;
            $display("FAIL reset_drop: respValid=%b, required 0", respValid);
        end
        reset = 1'b1;
        n = 0;
        while (reqReady !== 1'b1 && n < 64) begin
            n++;
            tick();
        end
        checks++;
        if (n != CAP) begin
            fails++;
            $display("FAIL resweep_len: reqReady low for %0d cycles, required %0d", n, CAP);
        end
        issue(1'b0, 32'h8, '0, '0);
        issue(1'b0, 32'h0, '0, '0);
        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_reset_inflight: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_mask();
        test_errors();
        test_freeze();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
